// File: rtl/memory_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Data has priority; a starvation counter bounds how long an instruction fetch can wait.
module memory_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  // instruction requester
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  // data requester
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  // RAM port
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              busy
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIacc, StDacc} state_e;

  state_e              state_q, state_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                ram_ren_q, ram_ren_d;
  logic                ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_store_q, ram_store_d;

  logic data_req;
  logic data_grant;
  logic instr_grant;
  logic idle;
  logic acc_done;

  assign idle        = (state_q == StIdle);
  assign data_req    = dREN | dWEN;
  // Data wins unless the waiting fetch has already been passed over StarveMax times.
  assign data_grant  = idle & data_req & (~iREN | (starve_cnt_q < StarveMax));
  assign instr_grant = idle & ~data_grant & iREN;
  assign acc_done    = ~idle & ram_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (data_grant) begin
          state_d = StDacc;
        end else if (instr_grant) begin
          state_d = StIacc;
        end
      end
      StIacc, StDacc: begin
        if (ram_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = ~idle;
    ihit  = (state_q == StIacc) & ram_ready;
    dhit  = (state_q == StDacc) & ram_ready;
    iload = ram_load;
    dload = ram_load;
  end

  // ---------------------------------------------------------------------------
  // Starvation counter
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (idle) begin
      if (!iREN || instr_grant) begin
        starve_cnt_d = 4'd0;
      end else if (data_grant) begin
        starve_cnt_d = (starve_cnt_q == 4'hf) ? 4'hf : starve_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered RAM strobes, captured once at grant and held for the access
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    if (data_grant) begin
      ram_addr_d  = daddr;
      ram_store_d = dstore;
      ram_wen_d   = dWEN;
      ram_ren_d   = dREN & ~dWEN;
    end else if (instr_grant) begin
      ram_addr_d  = iaddr;
      ram_ren_d   = 1'b1;
      ram_wen_d   = 1'b0;
    end else if (acc_done) begin
      ram_ren_d   = 1'b0;
      ram_wen_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
    end else begin
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
    end
  end

  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_store = ram_store_q;

  hits_exclusive_a: assert property (@(posedge CLK) disable iff (RST) !(ihit && dhit));
  strobes_exclusive_a: assert property (@(posedge CLK) disable iff (RST) !(ram_ren && ram_wen));

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single RAM port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of one core. It runs a registered grant FSM with data-over-instruction priority and a starvation counter that bounds instruction-fetch delay. It drives the RAM strobes from registered state and returns completion pulses (ihit/dhit) to the pipeline, which uses them to stall or advance.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data grants allowed while an instruction request waits; range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- iREN  input  1  instruction read request; held until ihit.
- iaddr  input  ADDR_W  instruction address.
- ihit  output  1  instruction access complete, one-cycle pulse.
- iload  output  DATA_W  instruction data, valid when ihit.
- dREN  input  1  data read request; held until dhit.
- dWEN  input  1  data write request; held until dhit.
- daddr  input  ADDR_W  data address.
- dstore  input  DATA_W  write data.
- dhit  output  1  data access complete, one-cycle pulse.
- dload  output  DATA_W  read data, valid when dhit after a read.
- ram_ren  output  1  RAM read strobe, registered.
- ram_wen  output  1  RAM write strobe, registered.
- ram_addr  output  ADDR_W  RAM address, registered.
- ram_store  output  DATA_W  RAM write data, registered.
- ram_load  input  DATA_W  RAM read data, valid with ram_ready.
- ram_ready  input  1  RAM completes the current access this cycle.
- busy  output  1  high in IACC or DACC.

## Operation
- States: IDLE, IACC, DACC.
- Arbitration happens in IDLE only.
  - Data grant: (dREN|dWEN) and (!iREN or starve_cnt < STARVE_MAX). Next state is DACC.
  - Otherwise, if iREN, instruction grant. Next state is IACC.
  - Otherwise, stay in IDLE.
- On grant, register the following at the clock edge:
  - For IACC: ram_addr ← iaddr, ram_ren ← 1, ram_wen ← 0.
  - For DACC: ram_addr ← daddr, ram_store ← dstore, ram_wen ← dWEN, ram_ren ← dREN & !dWEN. If both dREN and dWEN are set, the write wins.
- The registered strobes and address stay constant for the whole access. Requester inputs are not re-sampled.
- In IACC/DACC with ram_ready=1:
  - ihit (IACC) or dhit (DACC) = 1 combinationally.
  - iload/dload = ram_load.
  - Next state is IDLE. Strobes clear to 0 at that edge.
- In IACC/DACC with ram_ready=0: hold state; hits stay 0.
- The FSM always passes through one IDLE cycle between accesses. The completed requester therefore sees its hit before it is re-arbitrated.
- starve_cnt (4 bits) updates at each data grant or instruction grant:
  - Data grant with iREN=1: starve_cnt + 1, saturating at 15.
  - Instruction grant: 0.
  - In any IDLE cycle with iREN=0: 0.
- If a requester drops its request mid-access, the access still completes and the hit still pulses. The pipeline ignores it.
- ihit and dhit are never high together.
- iload and dload both mirror ram_load; only the matching hit qualifies them.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE; starve_cnt = 0.
  - ram_ren = ram_wen = 0, ram_addr = 0, ram_store = 0.
  - busy = 0, ihit = dhit = 0.
- Request seen in IDLE in cycle N gives ram strobe high in cycle N+1. Earliest hit is N+1, with a zero-wait RAM.
- Request-to-hit latency = 1 + W cycles, where W = cycles ram_ready stays low in the ACC state. The next grant happens no earlier than hit cycle + 1, in IDLE; strobes rise at + 2.
- Worst-case instruction wait under continuous data traffic: STARVE_MAX data accesses, then the instruction access.
- RST asserted mid-access: strobes drop in the same cycle, with no hit. The requester must re-issue after RST falls.
- ram_ready in IDLE is ignored; no hit is produced.

## Test plan
- Reset: assert RST mid-DACC with ram_wen=1 -> ram_wen=0 and busy=0 immediately, no dhit; after release, state IDLE and outputs all 0.
- Single fetch: iREN=1, iaddr=0x00000040, RAM W=2, ram_load=0x8C220004 -> ram_ren high cycles 1–3, ihit pulse in cycle 3 with iload=0x8C220004, ram_ren=0 in cycle 4.
- Simultaneous requests: iREN=1 and dWEN=1 in the same IDLE cycle, daddr=0x100, dstore=0xDEADBEEF -> data granted first: ram_wen=1, ram_addr=0x100, ram_store=0xDEADBEEF; after dhit, one IDLE cycle, then instruction granted.
- Starvation: iREN held, dREN re-asserted every IDLE cycle, STARVE_MAX=4 -> exactly 4 dhit pulses, then an ihit, with starve_cnt returning to 0.
- dREN=dWEN=1 with daddr=0x200 -> ram_wen=1, ram_ren=0.
- Dropped request: dREN drops during DACC -> access finishes and dhit still pulses once.
- Zero-wait back-to-back fetches (ram_ready tied 1, iREN held) -> ihit every 2 cycles, never two consecutive cycles.
